// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_pkg
// Purpose  : Shared definitions for the param_calc window buffer: default
//            widths, sign-magnitude sample field positions, and the bank /
//            read-FSM state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package pc_pkg;

    // Default sample and address widths
    localparam int PC_DATA_WIDTH = 18;
    localparam int PC_ADDR_WIDTH = 8;
    localparam int PC_WINDOW     = 16;

    // Sign-magnitude sample layout: 1 sign, 5 integer, 12 fraction bits
    localparam int PC_SIGN_BIT   = 17;
    localparam int PC_INT_MSB    = 16;
    localparam int PC_INT_LSB    = 12;
    localparam int PC_FRAC_MSB   = 11;
    localparam int PC_FRAC_LSB   = 0;

    // Storage bank life cycle
    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_LOCKED  = 2'd3
    } bank_state_t;

    // Read-side hand-off to param_calc
    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_BUSY  = 2'd2
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/pc_bank_ram.sv
`default_nettype none
// ============================================================================
// Module   : pc_bank_ram
// Purpose  : Single-port synchronous-read RAM, DEPTH x DATA_WIDTH. One
//            address serves both write and read; read data is registered
//            and holds while re is low.
// Ports    : clk, we, re, addr, wdata (in); rdata (out)
// Revision : 1.0 - initial release
// ============================================================================
module pc_bank_ram
    import pc_pkg::*;
#(
    parameter int DATA_WIDTH = PC_DATA_WIDTH,
    parameter int DEPTH      = PC_WINDOW,
    parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= r_mem[addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_window_buf.sv
`default_nettype none
// ============================================================================
// Module   : pc_window_buf
// Purpose  : Ping-pong window buffer between the EEG sample stream and
//            param_calc. Two banks of WINDOW samples fill alternately; a full
//            bank is locked and announced with a one-cycle start pulse, then
//            released on param_calc_finish.
// Ports    : clk, reset              - clock, synchronous active-high reset
//            in_valid/in_data/in_ready - sample input stream
//            pc_fifo_addr/pc_fifo_read/pc_fifo_data - locked-window read port
//            start / param_calc_finish - window hand-off
//            drop_cnt                  - dropped-sample count (option only)
// Options  : PC_BUF_DROP_EN - in_ready tied high; samples arriving with no
//            writable bank are dropped and counted in drop_cnt (saturating).
// Revision : 1.0 - initial release
// ============================================================================
module pc_window_buf
    import pc_pkg::*;
#(
    parameter int DATA_WIDTH = PC_DATA_WIDTH,
    parameter int ADDR_WIDTH = PC_ADDR_WIDTH,
    parameter int WINDOW     = PC_WINDOW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] pc_fifo_addr,
    input  logic                  pc_fifo_read,
    output logic [DATA_WIDTH-1:0] pc_fifo_data,
    output logic                  start,
    input  logic                  param_calc_finish
`ifdef PC_BUF_DROP_EN
    ,
    output logic [15:0]           drop_cnt
`endif
);

    localparam int                    c_ram_aw   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [c_ram_aw-1:0]   c_last_ptr = c_ram_aw'(WINDOW - 1);
    localparam logic [ADDR_WIDTH:0]   c_window   = (ADDR_WIDTH + 1)'(WINDOW);

    bank_state_t           r_bank_state [2];
    logic                  r_wr_bank;
    logic [c_ram_aw-1:0]   r_wr_ptr;
    rd_state_t             r_rd_state;
    logic                  r_rd_bank;
    logic                  r_rd_zero;
    logic                  r_rd_sel;

    logic                  w_writable;
    logic                  w_accept;
    logic                  w_wr_last;
    logic [1:0]            w_full_next;
    logic                  w_addr_ok;
    logic                  w_rd_en;
    logic [DATA_WIDTH-1:0] w_bank_q [2];

    // The write bank only ever points at a bank that is not yet full, unless
    // both banks are occupied; so checking the write bank alone is exact.
    assign w_writable = (r_bank_state[r_wr_bank] == BANK_EMPTY) ||
                        (r_bank_state[r_wr_bank] == BANK_FILLING);
    assign w_accept   = in_valid && w_writable;
    assign w_wr_last  = (r_wr_ptr == c_last_ptr);

`ifdef PC_BUF_DROP_EN
    assign in_ready = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= 16'd0;
        end else if (in_valid && !w_writable && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`else
    assign in_ready = w_writable;
`endif

    // A bank counts as full if it already is, or if it completes this cycle;
    // this lets start follow the last accept (or a finish) by one cycle.
    assign w_full_next[0] = (r_bank_state[0] == BANK_FULL) ||
                            (w_accept && w_wr_last && (r_wr_bank == 1'b0));
    assign w_full_next[1] = (r_bank_state[1] == BANK_FULL) ||
                            (w_accept && w_wr_last && (r_wr_bank == 1'b1));

    assign w_addr_ok = ({1'b0, pc_fifo_addr} < c_window);
    assign w_rd_en   = pc_fifo_read && (r_rd_state == R_BUSY) && w_addr_ok;

    // Write and read never hit the same bank in one cycle, so each RAM's
    // single port is steered by its own write enable.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic                w_we;
        logic                w_re;
        logic [c_ram_aw-1:0] w_addr;

        assign w_we   = w_accept && (r_wr_bank == 1'(b));
        assign w_re   = w_rd_en && (r_rd_bank == 1'(b));
        assign w_addr = w_we ? r_wr_ptr : pc_fifo_addr[c_ram_aw-1:0];

        pc_bank_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (WINDOW),
            .AW         (c_ram_aw)
        ) u_ram (
            .clk   (clk),
            .we    (w_we),
            .re    (w_re),
            .addr  (w_addr),
            .wdata (in_data),
            .rdata (w_bank_q[b])
        );
    end

    // Write pointer and write-bank selection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_bank <= 1'b0;
            r_wr_ptr  <= '0;
        end else if (w_accept) begin
            if (w_wr_last) begin
                r_wr_ptr  <= '0;
                r_wr_bank <= ~r_wr_bank;
            end else begin
                r_wr_ptr  <= r_wr_ptr + 1'b1;
            end
        end
    end

    // Bank states and read-side FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bank_state[0] <= BANK_EMPTY;
            r_bank_state[1] <= BANK_EMPTY;
            r_rd_state      <= R_IDLE;
            r_rd_bank       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_bank_state[r_wr_bank] <= w_wr_last ? BANK_FULL : BANK_FILLING;
            end
            case (r_rd_state)
                R_IDLE: begin
                    if (w_full_next[0]) begin
                        r_rd_bank  <= 1'b0;
                        r_rd_state <= R_START;
                    end else if (w_full_next[1]) begin
                        r_rd_bank  <= 1'b1;
                        r_rd_state <= R_START;
                    end
                end
                R_START: begin
                    r_bank_state[r_rd_bank] <= BANK_LOCKED;
                    r_rd_state              <= R_BUSY;
                end
                R_BUSY: begin
                    if (param_calc_finish) begin
                        r_bank_state[r_rd_bank] <= BANK_EMPTY;
                        // Pass straight through idle if the other bank is waiting
                        if (w_full_next[~r_rd_bank]) begin
                            r_rd_bank  <= ~r_rd_bank;
                            r_rd_state <= R_START;
                        end else begin
                            r_rd_state <= R_IDLE;
                        end
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    // Read data: RAM output holds between reads; a flag forces zero for
    // out-of-range addresses and reads outside R_BUSY.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_zero <= 1'b1;
            r_rd_sel  <= 1'b0;
        end else if (pc_fifo_read) begin
            r_rd_zero <= !w_rd_en;
            r_rd_sel  <= r_rd_bank;
        end
    end

    assign pc_fifo_data = r_rd_zero ? '0 : w_bank_q[r_rd_sel];
    assign start        = (r_rd_state == R_START);

endmodule
`default_nettype wire
